pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC and fetch stage in front of the instruction RAM
// Optional PC_BOUNDS_CHECK_EN halts with bound_error when the PC would leave the program.
module pc_fetch_unit #(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          BOOT_CYCLES = 2,
   parameter int          PROG_DEPTH  = 71,
   parameter logic [31:0] NOP_WORD    = 32'h5C000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  halt,
   input  logic                  jump_enable,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   input  logic [31:0]           iram_data,
   output logic [ADDR_WIDTH-1:0] iram_address,
   output logic [31:0]           instruction,
   output logic [ADDR_WIDTH-1:0] instruction_pc,
   output logic                  instruction_valid,
   output logic                  halted,
   output logic                  bound_error
);

   if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15 || PROG_DEPTH < 1) begin : g_bad_params
      $error("pc_fetch_unit: BOOT_CYCLES must be 1..15 and PROG_DEPTH at least 1");
   end

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALT
   } state_t;

   // Leaving BOOT happens on the edge where the counter would become BOOT_CYCLES-1.
   localparam logic [3:0] BOOT_LAST = 4'((BOOT_CYCLES > 1) ? (BOOT_CYCLES - 2) : 0);

   state_t                  state_q, state_d;
   logic [3:0]              boot_cnt_q, boot_cnt_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [31:0]             instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
   logic                    valid_q, valid_d;
   logic                    halted_q, halted_d;
   logic [ADDR_WIDTH-1:0]   pc_inc;
   logic                    jump_oob;
   logic                    adv_oob;

   assign pc_inc = pc_q + ADDR_WIDTH'(1);

`ifdef PC_BOUNDS_CHECK_EN
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(PROG_DEPTH);

   logic bound_err_q, bound_err_d;

   assign jump_oob    = ({1'b0, jump_target} >= DEPTH_L);
   assign adv_oob     = ({1'b0, pc_inc} >= DEPTH_L);
   assign bound_error = bound_err_q;
`else
   assign jump_oob    = 1'b0;
   assign adv_oob     = 1'b0;
   assign bound_error = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
`ifdef PC_BOUNDS_CHECK_EN
      bound_err_d = bound_err_q;
`endif
      case (state_q)
         ST_BOOT: begin
            boot_cnt_d = boot_cnt_q + 4'd1;
            if (boot_cnt_q >= BOOT_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_d  = ST_HALT;
               instr_d  = NOP_WORD;
               valid_d  = 1'b0;
               halted_d = 1'b1;
            end else if ((jump_enable && jump_oob) || (!jump_enable && !stall && adv_oob)) begin
               state_d  = ST_HALT;
               valid_d  = 1'b0;
               halted_d = 1'b1;
`ifdef PC_BOUNDS_CHECK_EN
               bound_err_d = 1'b1;
`endif
            end else if (jump_enable) begin
               // The word fetched at the old PC this cycle is squashed.
               pc_d    = jump_target;
               instr_d = NOP_WORD;
               valid_d = 1'b0;
            end else if (!stall) begin
               instr_d    = iram_data;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               pc_d       = pc_inc;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= 4'd0;
         pc_q       <= '0;
         instr_q    <= NOP_WORD;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
         bound_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
`ifdef PC_BOUNDS_CHECK_EN
         bound_err_q <= bound_err_d;
`endif
      end
   end

   assign iram_address      = pc_q;
   assign instruction       = instr_q;
   assign instruction_pc    = instr_pc_q;
   assign instruction_valid = valid_q;
   assign halted            = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit with RAM word k = k
module tb_pc_fetch_unit;

   localparam logic [31:0] NOP = 32'h5C000000;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        halt;
   logic        jump_enable;
   logic [9:0]  jump_target;
   logic [31:0] iram_data;
   logic [9:0]  iram_address;
   logic [31:0] instruction;
   logic [9:0]  instruction_pc;
   logic        instruction_valid;
   logic        halted;
   logic        bound_error;

   typedef struct {
      logic [31:0] instr;
      logic [9:0]  pc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   assign iram_data = {22'd0, iram_address};

   pc_fetch_unit dut (
      .clock             (clock),
      .reset             (reset),
      .stall             (stall),
      .halt              (halt),
      .jump_enable       (jump_enable),
      .jump_target       (jump_target),
      .iram_data         (iram_data),
      .iram_address      (iram_address),
      .instruction       (instruction),
      .instruction_pc    (instruction_pc),
      .instruction_valid (instruction_valid),
      .halted            (halted),
      .bound_error       (bound_error)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic exp_t sb_pop();
      exp_t e;
      if (sb.size() == 0) begin
         e.instr = 'x;
         e.pc    = 'x;
      end else begin
         e = sb.pop_front();
      end
      return e;
   endfunction

   // Predicts one fetch from pc a (RAM returns a), advances and checks it.
   task automatic fetch_one(input logic [9:0] a, input string name);
      exp_t e;
      sb.push_back('{instr: {22'd0, a}, pc: a});
      tick();
      e = sb_pop();
      n_checks++;
      if (instruction_valid !== 1'b1 || instruction !== e.instr || instruction_pc !== e.pc) begin
         n_fail++;
         $display("FAIL %s: valid=%b instr=%h ipc=%0d, expected valid=1 instr=%h ipc=%0d",
                  name, instruction_valid, instruction, instruction_pc, e.instr, e.pc);
      end
   endtask

   task automatic reset_and_boot();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      stall = 0; halt = 0; jump_enable = 0; jump_target = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks++;
      if (iram_address !== 10'd0 || instruction_valid !== 1'b0 || instruction !== NOP ||
          instruction_pc !== 10'd0 || halted !== 1'b0 || bound_error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: pc=%0d valid=%b instr=%h ipc=%0d halted=%b berr=%b, expected 0/0/%h/0/0/0",
                  iram_address, instruction_valid, instruction, instruction_pc, halted, bound_error, NOP);
      end
      tick();
      n_checks++;
      if (instruction_valid !== 1'b0 || iram_address !== 10'd0) begin
         n_fail++;
         $display("FAIL boot_hold: valid=%b pc=%0d, expected valid=0 pc=0", instruction_valid, iram_address);
      end
      for (int k = 0; k < 3; k++) fetch_one(10'(k), "boot_first_fetch");
   endtask

   task automatic test_stall();
      fetch_one(10'd3, "pre_stall");
      fetch_one(10'd4, "pre_stall");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (iram_address !== 10'd5 || instruction !== 32'd4 || instruction_valid !== 1'b1 ||
             instruction_pc !== 10'd4) begin
            n_fail++;
            $display("FAIL stall_hold: pc=%0d instr=%h valid=%b ipc=%0d, expected 5/4/1/4",
                     iram_address, instruction, instruction_valid, instruction_pc);
         end
      end
      stall = 1'b0;
      fetch_one(10'd5, "stall_resume");
   endtask

   task automatic test_jump();
      reset_and_boot();
      fetch_one(10'd0, "jump_pre");
      jump_enable = 1'b1; jump_target = 10'd7;
      tick();
      jump_enable = 1'b0;
      n_checks++;
      if (iram_address !== 10'd7 || instruction_valid !== 1'b0 || instruction !== NOP) begin
         n_fail++;
         $display("FAIL jump_squash: pc=%0d valid=%b instr=%h, expected 7/0/%h",
                  iram_address, instruction_valid, instruction, NOP);
      end
      fetch_one(10'd7, "jump_target_fetch");
      stall = 1'b1; jump_enable = 1'b1; jump_target = 10'd3;
      tick();
      stall = 1'b0; jump_enable = 1'b0;
      n_checks++;
      if (iram_address !== 10'd3 || instruction_valid !== 1'b0 || instruction !== NOP) begin
         n_fail++;
         $display("FAIL jump_with_stall: pc=%0d valid=%b instr=%h, expected 3/0/%h",
                  iram_address, instruction_valid, instruction, NOP);
      end
      fetch_one(10'd3, "jump_stall_fetch");
   endtask

   task automatic test_halt();
      reset_and_boot();
      for (int k = 0; k < 9; k++) fetch_one(10'(k), "halt_pre");
      jump_enable = 1'b1; halt = 1'b1; jump_target = 10'd2;
      tick();
      halt = 1'b0;
      n_checks++;
      if (halted !== 1'b1 || iram_address !== 10'd9 || instruction_valid !== 1'b0 ||
          instruction !== NOP || bound_error !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_enter: halted=%b pc=%0d valid=%b instr=%h berr=%b, expected 1/9/0/%h/0",
                  halted, iram_address, instruction_valid, instruction, bound_error, NOP);
      end
      for (int i = 0; i < 4; i++) begin
         jump_enable = i[0]; stall = i[1]; jump_target = 10'd20;
         tick();
         n_checks++;
         if (halted !== 1'b1 || iram_address !== 10'd9 || instruction_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_frozen: halted=%b pc=%0d valid=%b, expected 1/9/0",
                     halted, iram_address, instruction_valid);
         end
      end
      jump_enable = 1'b0; stall = 1'b0;
   endtask

   task automatic test_reset_midrun();
      reset_and_boot();
      for (int k = 0; k < 40; k++) fetch_one(10'(k), "midrun_pre");
      reset = 1'b1; jump_enable = 1'b1; jump_target = 10'd99;
      tick();
      reset = 1'b0; jump_enable = 1'b0;
      n_checks++;
      if (iram_address !== 10'd0 || instruction_valid !== 1'b0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset: pc=%0d valid=%b halted=%b, expected 0/0/0",
                  iram_address, instruction_valid, halted);
      end
      tick();
      n_checks++;
      if (instruction_valid !== 1'b0 || iram_address !== 10'd0) begin
         n_fail++;
         $display("FAIL midrun_reboot: valid=%b pc=%0d, expected 0/0", instruction_valid, iram_address);
      end
      fetch_one(10'd0, "midrun_first_fetch");
   endtask

   task automatic test_bounds();
      reset_and_boot();
      jump_enable = 1'b1; jump_target = 10'd70;
      tick();
      jump_enable = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
      tick();
      n_checks++;
      if (halted !== 1'b1 || bound_error !== 1'b1 || iram_address !== 10'd70 || instruction_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bounds_halt: halted=%b berr=%b pc=%0d valid=%b, expected 1/1/70/0",
                  halted, bound_error, iram_address, instruction_valid);
      end
`else
      fetch_one(10'd70, "bounds_advance");
      n_checks++;
      if (iram_address !== 10'd71 || halted !== 1'b0 || bound_error !== 1'b0) begin
         n_fail++;
         $display("FAIL bounds_off: pc=%0d halted=%b berr=%b, expected 71/0/0",
                  iram_address, halted, bound_error);
      end
      jump_enable = 1'b1; jump_target = 10'd1023;
      tick();
      jump_enable = 1'b0;
      fetch_one(10'd1023, "wrap_fetch");
      n_checks++;
      if (iram_address !== 10'd0) begin
         n_fail++;
         $display("FAIL wrap_pc: pc=%0d, expected 0", iram_address);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_stall();
      test_jump();
      test_halt();
      test_reset_midrun();
      test_bounds();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
